mopshub_test_sequencer: RTL and testbench

Parametrised, synthesizable sequencer that runs the MOPSHUB bring-up test flow over up to 32 CAN buses: power-init wait, oscillator auto-trim release, sign-on, then per-bus RX test, end-wait pulse, a programmable gap, and a TX test. It sits between the bench/control host and `data_generator`/`mopshub_top`. It adds bus-mask iteration, per-phase timeouts and pass/fail accounting.

---
 rtl/mopshub_seq_pkg.sv | 43 ++++
 rtl/mopshub_seq_timer.sv | 31 +++
 rtl/mopshub_test_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_mopshub_test_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mopshub_seq_pkg.sv
// mopshub_seq_pkg: shared types and constants for the MOPSHUB test sequencer.
// This package holds the FSM state enum, the default timing constants, the bus
// index width, and two small helper functions.
package mopshub_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POWER,
        S_SIGNON,
        S_NEXT,
        S_RX,
        S_EWAIT,
        S_GAP,
        S_TX,
        S_ADV,
        S_BDONE,
        S_FINISH
    } seq_state_t;

    localparam int SEQ_GAP_DEFAULT     = 120;
    localparam int SEQ_TIMEOUT_DEFAULT = 65535;
    localparam int BUS_IDX_W           = 5;
    localparam int CNT_W               = 6;

    // Priority encoder that finds the lowest set bit of the mask.
    // It returns {found, index}.
    function automatic logic [BUS_IDX_W:0] lowest_set(input logic [31:0] mask);
        logic [BUS_IDX_W:0] res;
        res = '0;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i]) begin
                res = {1'b1, BUS_IDX_W'(i)};
            end
        end
        return res;
    endfunction

    // Saturating increment for the pass and fail counters. The counter holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mopshub_seq_timer.sv
// mopshub_seq_timer: TMR_W-bit loadable down-counter.
// The counter stops at zero. expired is high while the count is zero.
// The sequencer uses this one timer both for the gap count and for the timeouts.
module mopshub_seq_timer #(
    parameter int TMR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_value,
    output logic [TMR_W-1:0] value,
    output logic             expired
);

    logic [TMR_W-1:0] value_q;

    // Load on request. Otherwise count down toward zero and hold there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_value;
        end else if (value_q != '0) begin
            value_q <= value_q - 1'b1;
        end
    end

    assign value   = value_q;
    assign expired = (value_q == '0);

endmodule

// File: rtl/mopshub_test_sequencer.sv
// mopshub_test_sequencer: runs the MOPSHUB bring-up flow.
// The flow is power-init, then trim release, then sign-on, then for each bus in the
// mask: RX test, end-wait pulse, gap, TX test. Every wait state has a timeout.
// Pass and fail results are counted per run.
// Optional custom-message phase after TX: define MOPSHUB_SEQ_ADVANCED_EN.
module mopshub_test_sequencer
    import mopshub_seq_pkg::*;
#(
    parameter int N_BUSES        = 32,
    parameter int GAP_CYCLES     = SEQ_GAP_DEFAULT,
    parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT,
    parameter int TMR_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_BUSES-1:0]   bus_mask,
    input  logic                 end_power_init,
    input  logic                 sign_on_sig,
    input  logic                 test_rx_end,
    input  logic                 test_tx_end,
    input  logic                 costum_msg_end,
    output logic                 osc_auto_trim,
    output logic                 test_rx,
    output logic                 test_tx,
    output logic                 test_advanced,
    output logic                 endwait_all,
    output logic [BUS_IDX_W-1:0] bus_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt
);

    // The timer is loaded with N-1 so that a wait state lasts exactly N cycles.
    localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_state_t           state_q, state_d;
    logic [31:0]          mask_q;
    logic [BUS_IDX_W-1:0] bus_sel_q;
    logic                 osc_q, rx_q, tx_q, ew_q, busy_q, done_q, fail_q;
    logic [CNT_W-1:0]     pass_q, fcnt_q;
    logic                 init_timeout, phase_timeout;
    logic                 found;
    logic [BUS_IDX_W-1:0] found_idx;
    logic                 tmr_load, tmr_expired;
    logic [TMR_W-1:0]     tmr_load_value;
    // The count itself is not needed for sequencing. It stays on the port as a debug tap.
    logic [TMR_W-1:0]     tmr_value_unused;

    // Bits are cleared as each bus finishes, so the lowest set bit is the next bus.
    assign {found, found_idx} = lowest_set(mask_q);

    // The timer reloads on every state change: gap length for GAP, timeout otherwise.
    assign tmr_load       = (state_d != state_q);
    assign tmr_load_value = (state_d == S_GAP) ? GAP_LOAD : TMO_LOAD;

    mopshub_seq_timer #(.TMR_W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .value      (tmr_value_unused),
        .expired    (tmr_expired)
    );

    // Next-state decision. In each state the strobe is checked before the timeout.
    always_comb begin
        state_d       = state_q;
        init_timeout  = 1'b0;
        phase_timeout = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_POWER;
            S_POWER: begin
                if (end_power_init) state_d = S_SIGNON;
                else if (tmr_expired) begin
                    state_d      = S_FINISH;
                    init_timeout = 1'b1;
                end
            end
            S_SIGNON: begin
                if (sign_on_sig) state_d = S_NEXT;
                else if (tmr_expired) begin
                    state_d      = S_FINISH;
                    init_timeout = 1'b1;
                end
            end
            S_NEXT:   state_d = found ? S_RX : S_FINISH;
            S_RX: begin
                if (test_rx_end) state_d = S_EWAIT;
                else if (tmr_expired) begin
                    state_d       = S_NEXT;
                    phase_timeout = 1'b1;
                end
            end
            S_EWAIT:  state_d = (GAP_CYCLES > 0) ? S_GAP : S_TX;
            S_GAP:    if (tmr_expired) state_d = S_TX;
            S_TX: begin
                if (test_tx_end) begin
`ifdef MOPSHUB_SEQ_ADVANCED_EN
                    state_d = S_ADV;
`else
                    state_d = S_BDONE;
`endif
                end else if (tmr_expired) begin
                    state_d       = S_NEXT;
                    phase_timeout = 1'b1;
                end
            end
`ifdef MOPSHUB_SEQ_ADVANCED_EN
            S_ADV: begin
                if (costum_msg_end) state_d = S_BDONE;
                else if (tmr_expired) begin
                    state_d       = S_NEXT;
                    phase_timeout = 1'b1;
                end
            end
`endif
            S_BDONE:  state_d = S_NEXT;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register, registered phase outputs, mask bookkeeping and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            bus_sel_q <= '0;
            osc_q     <= 1'b1;
            rx_q      <= 1'b0;
            tx_q      <= 1'b0;
            ew_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            pass_q    <= '0;
            fcnt_q    <= '0;
        end else begin
            state_q <= state_d;
            rx_q    <= (state_d == S_RX);
            tx_q    <= (state_d == S_TX);
            ew_q    <= (state_d == S_EWAIT);
            busy_q  <= (state_d != S_IDLE) && (state_d != S_FINISH);
            done_q  <= (state_d == S_FINISH);
            if (state_q == S_IDLE && start) begin
                mask_q <= 32'(bus_mask);
                pass_q <= '0;
                fcnt_q <= '0;
                fail_q <= 1'b0;
                osc_q  <= 1'b1;
            end
            if (state_q == S_POWER && end_power_init) osc_q <= 1'b0;
            if (init_timeout) fail_q <= 1'b1;
            if (state_q == S_NEXT && found) bus_sel_q <= found_idx;
            if (phase_timeout) begin
                fcnt_q            <= sat_inc(fcnt_q);
                fail_q            <= 1'b1;
                mask_q[bus_sel_q] <= 1'b0;
            end
            if (state_q == S_BDONE) begin
                pass_q            <= sat_inc(pass_q);
                mask_q[bus_sel_q] <= 1'b0;
            end
        end
    end

`ifdef MOPSHUB_SEQ_ADVANCED_EN
    logic adv_q;
    // Custom-message phase level. It is high exactly while the FSM is in ADV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) adv_q <= 1'b0;
        else     adv_q <= (state_d == S_ADV);
    end
    assign test_advanced = adv_q;
`else
    logic unused_costum;
    assign unused_costum = costum_msg_end;
    assign test_advanced = 1'b0;
`endif

    assign osc_auto_trim = osc_q;
    assign test_rx       = rx_q;
    assign test_tx       = tx_q;
    assign endwait_all   = ew_q;
    assign bus_sel       = bus_sel_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign fail          = fail_q;
    assign pass_cnt      = pass_q;
    assign fail_cnt      = fcnt_q;

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// tb_mopshub_test_sequencer: table-driven runs of the sequencer, answered by an in-bench
// responder that gives each completion strobe 10 cycles after its phase starts.
// It also has hand-written sequences for an asynchronous reset during TX and for the
// ADV phase, which exists when MOPSHUB_SEQ_ADVANCED_EN is defined.
module tb_mopshub_test_sequencer;

    localparam int TMO = 200;
    localparam int GAP = 120;
`ifdef MOPSHUB_SEQ_ADVANCED_EN
    localparam bit ADV_EN = 1'b1;
`else
    localparam bit ADV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bus_mask = '0;
    logic        end_power_init = 1'b0, sign_on_sig = 1'b0, test_rx_end = 1'b0;
    logic        test_tx_end = 1'b0, costum_msg_end = 1'b0;
    logic        osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all;
    logic        busy, done, fail;
    logic [4:0]  bus_sel;
    logic [5:0]  pass_cnt, fail_cnt;

    mopshub_test_sequencer #(
        .N_BUSES(32), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .TMR_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus_mask(bus_mask),
        .end_power_init(end_power_init), .sign_on_sig(sign_on_sig),
        .test_rx_end(test_rx_end), .test_tx_end(test_tx_end),
        .costum_msg_end(costum_msg_end),
        .osc_auto_trim(osc_auto_trim), .test_rx(test_rx), .test_tx(test_tx),
        .test_advanced(test_advanced), .endwait_all(endwait_all),
        .bus_sel(bus_sel), .busy(busy), .done(done), .fail(fail),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mask;
        bit          pw_ok, so_ok, rx_ok, tx_ok;
        int          exp_pass, exp_fcnt;
        bit          exp_fail;
        logic [31:0] exp_tested;
        bit          exp_osc;
    } vec_t;

    vec_t vecs[9];
    int   tests = 0;
    int   fails = 0;

    // Results of the last run. They are captured at the done pulse or at the stop point.
    int          r_pass, r_fcnt, r_gap, r_ew_max, r_tx_len, r_adv_seen, r_adv_len, r_adv_bus;
    int          r_done_seen;
    bit          r_fail, r_order_ok, r_busy_at_done, r_osc_at_done, r_done_after;
    bit          r_busy_after_start, r_stopped;
    logic [31:0] r_tested;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start one run and act as the responder for it, one iteration per cycle.
    // The run ends at done. If stop_bus >= 0, it ends as soon as TX of that bus is seen.
    task automatic run_seq(input logic [31:0] mask, input bit pw_ok, input bit so_ok,
                           input bit rx_ok, input bit tx_ok, input int stop_bus);
        int pw_c = 0, so_c = 0, rx_c = 0, tx_c = 0, adv_c = 0, ew_c = 0;
        int last_ew = 0, last_bus = -1;
        bit so_given = 0, prev_rx = 0, prev_tx = 0, prev_adv = 0;
        r_pass = 0; r_fcnt = 0; r_gap = -1; r_ew_max = 0; r_tx_len = -1;
        r_adv_seen = 0; r_adv_len = -1; r_adv_bus = -1; r_done_seen = 0;
        r_fail = 0; r_order_ok = 1; r_busy_at_done = 1; r_osc_at_done = 0;
        r_done_after = 1; r_stopped = 0; r_tested = '0;
        @(negedge clk);
        bus_mask = mask;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r_busy_after_start = busy;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (test_rx && !prev_rx) begin
                r_tested = r_tested | (32'd1 << bus_sel);
                if (int'(bus_sel) <= last_bus) r_order_ok = 0;
                last_bus = int'(bus_sel);
            end
            if (endwait_all) begin
                if (ew_c == 0) last_ew = cyc;
                ew_c++;
            end else begin
                if (ew_c > r_ew_max) r_ew_max = ew_c;
                ew_c = 0;
            end
            if (test_tx && !prev_tx) r_gap = cyc - last_ew;
            if (stop_bus >= 0 && test_tx && int'(bus_sel) == stop_bus) begin
                r_stopped = 1;
                r_pass = int'(pass_cnt);
                break;
            end
            if (done) begin
                r_done_seen++;
                r_pass = int'(pass_cnt);
                r_fcnt = int'(fail_cnt);
                r_fail = fail;
                r_busy_at_done = busy;
                r_osc_at_done = osc_auto_trim;
                break;
            end
            if (busy && osc_auto_trim) pw_c++; else pw_c = 0;
            end_power_init = pw_ok && (pw_c == 10);
            sign_on_sig = 1'b0;
            if (busy && !osc_auto_trim && !so_given) begin
                so_c++;
                if (so_c == 10) begin
                    sign_on_sig = so_ok;
                    so_given = 1;
                end
            end
            if (test_rx) rx_c++; else rx_c = 0;
            test_rx_end = rx_ok && (rx_c == 10);
            if (test_tx) tx_c++;
            else begin
                if (prev_tx) r_tx_len = tx_c;
                tx_c = 0;
            end
            test_tx_end = tx_ok && (tx_c == 10);
            if (test_advanced) begin
                adv_c++;
                r_adv_bus = int'(bus_sel);
            end else begin
                if (prev_adv) begin
                    r_adv_len = adv_c;
                    r_adv_seen++;
                end
                adv_c = 0;
            end
            costum_msg_end = (adv_c == 10);
            prev_rx = test_rx;
            prev_tx = test_tx;
            prev_adv = test_advanced;
            @(negedge clk);
        end
        end_power_init = 0; sign_on_sig = 0; test_rx_end = 0; test_tx_end = 0;
        costum_msg_end = 0;
        if (r_done_seen > 0) begin
            @(negedge clk);
            r_done_after = done;
        end
    endtask

    initial begin
        // mask, pw, so, rx, tx, pass, fcnt, fail, tested buses, osc at done
        vecs[0] = '{32'h0000_0005, 1, 1, 1, 1, 2,  0, 0, 32'h0000_0005, 0};
        vecs[1] = '{32'h0000_0001, 1, 1, 1, 0, 0,  1, 1, 32'h0000_0001, 0};
        vecs[2] = '{32'h0000_0005, 0, 1, 1, 1, 0,  0, 1, 32'h0000_0000, 1};
        vecs[3] = '{32'h0000_0005, 1, 0, 1, 1, 0,  0, 1, 32'h0000_0000, 0};
        vecs[4] = '{32'h0000_0000, 1, 1, 1, 1, 0,  0, 0, 32'h0000_0000, 0};
        vecs[5] = '{32'h8000_0012, 1, 1, 0, 1, 0,  3, 1, 32'h8000_0012, 0};
        vecs[6] = '{32'h0000_0006, 1, 1, 1, 0, 0,  2, 1, 32'h0000_0006, 0};
        vecs[7] = '{32'hFFFF_FFFF, 1, 1, 1, 1, 32, 0, 0, 32'hFFFF_FFFF, 0};
        vecs[8] = '{32'h8000_0000, 1, 1, 1, 1, 1,  0, 0, 32'h8000_0000, 0};

        repeat (3) @(negedge clk);
        check("reset_flags", 32'({osc_auto_trim, test_rx, test_tx, test_advanced,
                                  endwait_all, busy, done, fail}), 32'h80);
        check("reset_bus_sel", 32'(bus_sel), 32'd0);
        check("reset_counts", 32'({pass_cnt, fail_cnt}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_seq(vecs[i].mask, vecs[i].pw_ok, vecs[i].so_ok, vecs[i].rx_ok,
                    vecs[i].tx_ok, -1);
            $display("[TB] run %0d mask=%h pass=%0d fail_cnt=%0d fail=%0b tested=%h gap=%0d",
                     i, vecs[i].mask, r_pass, r_fcnt, r_fail, r_tested, r_gap);
            check("busy_after_start", 32'(r_busy_after_start), 32'd1);
            check("done_seen", 32'(r_done_seen), 32'd1);
            check("done_single", 32'(r_done_after), 32'd0);
            check("busy_at_done", 32'(r_busy_at_done), 32'd0);
            check("pass_cnt", 32'(r_pass), 32'(vecs[i].exp_pass));
            check("fail_cnt", 32'(r_fcnt), 32'(vecs[i].exp_fcnt));
            check("fail", 32'(r_fail), 32'(vecs[i].exp_fail));
            check("tested_buses", r_tested, vecs[i].exp_tested);
            check("bus_order", 32'(r_order_ok), 32'd1);
            check("osc_at_done", 32'(r_osc_at_done), 32'(vecs[i].exp_osc));
            check("adv_phases", 32'(r_adv_seen), ADV_EN ? 32'(vecs[i].exp_pass) : 32'd0);
            if (vecs[i].exp_pass > 0) begin
                check("endwait_width", 32'(r_ew_max), 32'd1);
                check("gap_to_tx", 32'(r_gap), 32'(GAP + 1));
            end
            if (!vecs[i].tx_ok && vecs[i].rx_ok && vecs[i].exp_tested != 0)
                check("tx_timeout_len", 32'(r_tx_len), 32'(TMO));
        end

`ifdef MOPSHUB_SEQ_ADVANCED_EN
        run_seq(32'h8000_0000, 1, 1, 1, 1, -1);
        $display("[TB] adv run bus=%0d adv_len=%0d pass=%0d", r_adv_bus, r_adv_len, r_pass);
        check("adv_bus_sel", 32'(r_adv_bus), 32'd31);
        check("adv_len", 32'(r_adv_len), 32'd10);
        check("adv_pass", 32'(r_pass), 32'd1);
`endif

        // An asynchronous reset during TX of bus 3 must restore the reset values immediately.
        run_seq(32'h0000_0009, 1, 1, 1, 1, 3);
        $display("[TB] rst run stopped=%0b pass_before=%0d bus_sel=%0d", r_stopped, r_pass,
                 bus_sel);
        check("rst_reached_tx3", 32'(r_stopped), 32'd1);
        check("rst_pass_before", 32'(r_pass), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_flags", 32'({osc_auto_trim, test_rx, test_tx, test_advanced,
                                    endwait_all, busy, done, fail}), 32'h80);
        check("rst_mid_bus_sel", 32'(bus_sel), 32'd0);
        check("rst_mid_counts", 32'({pass_cnt, fail_cnt}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_seq(32'h0000_0001, 1, 1, 1, 1, -1);
        $display("[TB] post-rst run pass=%0d fail_cnt=%0d tested=%h", r_pass, r_fcnt, r_tested);
        check("post_rst_done", 32'(r_done_seen), 32'd1);
        check("post_rst_pass", 32'(r_pass), 32'd1);
        check("post_rst_fcnt", 32'(r_fcnt), 32'd0);
        check("post_rst_tested", r_tested, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
